// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED sequencer.
//   state_e : sequencer FSM states (IDLE/LOAD/RUN)
//   mode_e  : pattern modes (CHASE/BOUNCE/FILL/BLINK)
//   PAT_*   : idle and per-mode initial patterns
package led_seq_pkg;

  localparam int unsigned LED_W  = 8;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_CHASE  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  localparam logic [LED_W-1:0] PAT_IDLE        = 8'h00;
  localparam logic [LED_W-1:0] PAT_INIT_CHASE  = 8'h01;
  localparam logic [LED_W-1:0] PAT_INIT_BOUNCE = 8'h01;
  localparam logic [LED_W-1:0] PAT_INIT_FILL   = 8'h00;
  localparam logic [LED_W-1:0] PAT_INIT_BLINK  = 8'h00;

  // Pattern loaded when a mode is (re)entered.
  function automatic logic [LED_W-1:0] init_pattern(input mode_e m);
    logic [LED_W-1:0] p;
    p = PAT_IDLE;
    case (m)
      MODE_CHASE:  p = PAT_INIT_CHASE;
      MODE_BOUNCE: p = PAT_INIT_BOUNCE;
      MODE_FILL:   p = PAT_INIT_FILL;
      MODE_BLINK:  p = PAT_INIT_BLINK;
      default:     p = PAT_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/led_seq_if.sv
// Button/pause inputs and LED/mode/step outputs of the LED sequencer.
//   Tact1    : push button, active-low, asynchronous
//   PAUSE    : freeze pattern stepping
//   MODE     : current pattern mode
//   STEP     : one-cycle pulse per pattern advance
//   USER_LED : LED drive
interface led_seq_if;
  import led_seq_pkg::*;

  logic              Tact1;
  logic              PAUSE;
  logic [MODE_W-1:0] MODE;
  logic              STEP;
  logic [LED_W-1:0]  USER_LED;

  modport master (output Tact1, output PAUSE,
                  input  MODE, input STEP, input USER_LED);
  modport slave  (input  Tact1, input PAUSE,
                  output MODE, output STEP, output USER_LED);
endinterface

// File: rtl/led_seq_debounce.sv
// Button front end: 2-flop synchronizer, optional debounce filter, press pulse.
// Build option: LED_SEQ_DEBOUNCE_EN enables the debounce filter; without it a
// press is the falling edge of the synchronizer output and W_DB is unused.
//   clk_i    : clock
//   rst_i    : synchronous active-high reset
//   tact_n_i : raw active-low button
//   press_o  : one-cycle pulse on a (debounced) 1->0 transition
module led_seq_debounce #(
  parameter int unsigned W_DB = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tact_n_i,
  output logic press_o
);

  logic [1:0] sync_q;
  logic       press_q;

  // Synchronizer, idles high (button released).
  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], tact_n_i};
  end

`ifdef LED_SEQ_DEBOUNCE_EN
  logic            db_level_q, db_level_d;
  logic [W_DB-1:0] db_cnt_q,   db_cnt_d;

  // Level follows the synchronized input only after 2^W_DB differing cycles.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    if (sync_q[1] != db_level_q) begin
      if (db_cnt_q == '1) db_level_d = sync_q[1];
      else                db_cnt_d   = db_cnt_q + W_DB'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      db_level_q <= 1'b1;
      db_cnt_q   <= '0;
      press_q    <= 1'b0;
    end else begin
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= db_level_q & ~db_level_d;
    end
  end
`else
  // Pulse on the cycle the synchronizer output falls.
  always_ff @(posedge clk_i) begin
    if (rst_i) press_q <= 1'b0;
    else       press_q <= sync_q[1] & ~sync_q[0];
  end
`endif

  assign press_o = press_q;

endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: button cycles through four patterns, prescaler steps them.
// Build option: LED_SEQ_DEBOUNCE_EN enables button debouncing.
//   CLK_24MHz : sole clock
//   RST       : synchronous active-high reset
//   bus       : Tact1/PAUSE in, MODE/STEP/USER_LED out (led_seq_if.slave)
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int unsigned W_CNT  = 23,
  parameter int unsigned W_DB   = 18,
  parameter logic        LED_ON = 1'b0
) (
  input  logic     CLK_24MHz,
  input  logic     RST,
  led_seq_if.slave bus
);

  state_e           state_q;
  mode_e            mode_q;
  logic             step_q;
  logic [LED_W-1:0] pat_q, pat_adv_d;
  logic             dir_up_q, dir_adv_d;
  logic [W_CNT-1:0] presc_q;
  logic             press;

  led_seq_debounce #(.W_DB(W_DB)) u_debounce (
    .clk_i    (CLK_24MHz),
    .rst_i    (RST),
    .tact_n_i (bus.Tact1),
    .press_o  (press)
  );

  // Next pattern/direction for one advance in the current mode.
  always_comb begin
    pat_adv_d = pat_q;
    dir_adv_d = dir_up_q;
    case (mode_q)
      MODE_CHASE:  pat_adv_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
      MODE_BOUNCE: begin
        if (dir_up_q) begin
          if (pat_q[LED_W-1]) begin
            dir_adv_d = 1'b0;
            pat_adv_d = pat_q >> 1;
          end else begin
            pat_adv_d = pat_q << 1;
          end
        end else begin
          if (pat_q[0]) begin
            dir_adv_d = 1'b1;
            pat_adv_d = pat_q << 1;
          end else begin
            pat_adv_d = pat_q >> 1;
          end
        end
      end
      MODE_FILL:   pat_adv_d = {pat_q[LED_W-2:0], ~pat_q[LED_W-1]};
      MODE_BLINK:  pat_adv_d = ~pat_q;
      default:     pat_adv_d = pat_q;
    endcase
  end

  // Sequencer FSM with prescaler; a press always wins over a coincident tick.
  always_ff @(posedge CLK_24MHz) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_CHASE;
      step_q   <= 1'b0;
      pat_q    <= PAT_IDLE;
      dir_up_q <= 1'b1;
      presc_q  <= '1;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          pat_q   <= PAT_IDLE;
          presc_q <= '1;
          state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          pat_q    <= init_pattern(mode_q);
          dir_up_q <= 1'b1;
          presc_q  <= '1;
          state_q  <= ST_RUN;
        end
        ST_RUN: begin
          if (press) begin
            mode_q  <= mode_e'(mode_q + MODE_W'(1));
            presc_q <= '1;
            state_q <= ST_LOAD;
          end else if (bus.PAUSE) begin
            presc_q <= '1;
          end else if (presc_q == '0) begin
            presc_q  <= '1;
            step_q   <= 1'b1;
            pat_q    <= pat_adv_d;
            dir_up_q <= dir_adv_d;
          end else begin
            presc_q <= presc_q - W_CNT'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.MODE     = mode_q;
  assign bus.STEP     = step_q;
  // LED_ON=0: lit bits drive low, so the pattern is inverted.
  assign bus.USER_LED = pat_q ^ {LED_W{~LED_ON}};

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with W_CNT=4, W_DB=3, LED_ON=0.
module tb_led_seq_ctrl;

`ifdef LED_SEQ_DEBOUNCE_EN
  localparam int PRESS_LAT = 11;  // Tact1 low -> FSM sees press
`else
  localparam int PRESS_LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  logic [7:0] exp_pat;
  logic       exp_up;
  logic [1:0] exp_mode;
  logic [7:0] led_hold;
  logic [1:0] glitch_mode;

  led_seq_if bus ();

  led_seq_ctrl #(.W_CNT(4), .W_DB(3), .LED_ON(1'b0)) dut (
    .CLK_24MHz (clk),
    .RST       (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic model_init(input logic [1:0] m);
    exp_mode = m;
    exp_pat  = (m == 2'd0 || m == 2'd1) ? 8'h01 : 8'h00;
    exp_up   = 1'b1;
  endtask

  task automatic model_step();
    case (exp_mode)
      2'd0: exp_pat = {exp_pat[6:0], exp_pat[7]};
      2'd1: begin
        if (exp_up && exp_pat == 8'h80) begin exp_up = 1'b0; exp_pat = 8'h40; end
        else if (!exp_up && exp_pat == 8'h01) begin exp_up = 1'b1; exp_pat = 8'h02; end
        else if (exp_up) exp_pat = exp_pat * 2;
        else exp_pat = exp_pat / 2;
      end
      2'd2: exp_pat = {exp_pat[6:0], ~exp_pat[7]};
      default: exp_pat = ~exp_pat;
    endcase
  endtask

  // Starting one cycle after the previous step (or RUN entry), expect n steps 16 cycles apart.
  task automatic run_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      repeat (15) cyc();
      chk({tag, "_nostep"}, {7'd0, bus.STEP}, 8'h00);
      cyc();
      model_step();
      chk({tag, "_step"}, {7'd0, bus.STEP}, 8'h01);
      chk({tag, "_led"}, bus.USER_LED, ~exp_pat);
    end
  endtask

  // Press the button; ends one cycle after MODE changes (first RUN cycle).
  task automatic press(input string tag);
    logic [1:0] old_mode;
    bit         seen;
    old_mode = bus.MODE;
    seen = 1'b0;
    bus.Tact1 = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc();
      if (bus.MODE !== old_mode) seen = 1'b1;
    end
    chk({tag, "_mode"}, {6'd0, bus.MODE}, {6'd0, old_mode + 2'd1});
    cyc();
    bus.Tact1 = 1'b1;
    model_init(old_mode + 2'd1);
    chk({tag, "_init"}, bus.USER_LED, ~exp_pat);
  endtask

  initial begin
    rst = 1'b1;
    bus.Tact1 = 1'b1;
    bus.PAUSE = 1'b0;

    // Reset and CHASE.
    cyc();
    rst = 1'b0;
    chk("rst_led", bus.USER_LED, 8'hFF);
    chk("rst_mode", {6'd0, bus.MODE}, 8'h00);
    chk("rst_step", {7'd0, bus.STEP}, 8'h00);
    cyc();
    cyc();
    model_init(2'd0);
    chk("run_led", bus.USER_LED, 8'hFE);
    run_steps(8, "chase");

    // BOUNCE, FILL, BLINK, wrap to CHASE.
    press("p_bounce");
    run_steps(15, "bounce");
    press("p_fill");
    run_steps(16, "fill");
    chk("fill_wrap", bus.USER_LED, 8'hFF);
    press("p_blink");
    run_steps(4, "blink");
    press("p_chase");
    run_steps(1, "chase2");

    // PAUSE: no steps, LED frozen; press still advances MODE.
    bus.PAUSE = 1'b1;
    led_hold = bus.USER_LED;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("pause_step", {7'd0, bus.STEP}, 8'h00);
      chk("pause_led", bus.USER_LED, led_hold);
    end
    press("p_pause");
    for (int i = 0; i < 40; i++) begin
      cyc();
      chk("pause2_step", {7'd0, bus.STEP}, 8'h00);
      chk("pause2_led", bus.USER_LED, 8'hFE);
    end
    bus.PAUSE = 1'b0;
    run_steps(1, "unpause");

    // Press lands on the tick cycle: no step, pattern reloads.
    repeat (16 - PRESS_LAT) cyc();
    bus.Tact1 = 1'b0;
    repeat (PRESS_LAT) cyc();
    chk("align_step", {7'd0, bus.STEP}, 8'h00);
    chk("align_mode", {6'd0, bus.MODE}, 8'h02);
    chk("align_led", bus.USER_LED, ~exp_pat);
    bus.Tact1 = 1'b1;
    cyc();
    model_init(2'd2);
    chk("align_reload", bus.USER_LED, 8'hFF);
    run_steps(2, "fill2");

    // Glitching button: filtered out with debounce, one press per fall without.
    for (int i = 0; i < 10; i++) begin
      bus.Tact1 = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (4) cyc();
    end
    bus.Tact1 = 1'b1;
    repeat (20) cyc();
`ifdef LED_SEQ_DEBOUNCE_EN
    glitch_mode = 2'd2;
`else
    glitch_mode = 2'd3;
`endif
    chk("glitch_mode", {6'd0, bus.MODE}, {6'd0, glitch_mode});

    // Reset while a press is in progress.
    bus.Tact1 = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.Tact1 = 1'b1;
    chk("rst2_led", bus.USER_LED, 8'hFF);
    chk("rst2_mode", {6'd0, bus.MODE}, 8'h00);
    chk("rst2_step", {7'd0, bus.STEP}, 8'h00);
    cyc();
    cyc();
    chk("rst2_run_led", bus.USER_LED, 8'hFE);
    repeat (20) cyc();
    chk("rst2_nopress", {6'd0, bus.MODE}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
